// File: rtl/wb_line_memory.sv
`default_nettype none
// ============================================================================
// Module   : wb_line_memory
// Purpose  : Wishbone slave standing in for the physical memory behind the
//            cache arbiter. Serves 128-bit line reads and byte-masked line
//            writes from an internal array after a fixed access latency,
//            with request abort and a one-cycle ACK per completed transfer.
// Ports    : clk_i     - clock, all state updates on the rising edge
//            rst_i     - synchronous active-high reset (array is untouched)
//            cyc_i     - bus cycle valid
//            stb_i     - strobe; a request is present when cyc_i && stb_i
//            we_i      - 1 = line write, 0 = line read
//            adr_i     - line address
//            sel_i     - byte-lane enables for writes (bit i -> byte i)
//            dat_m_i   - write data
//            dat_s_o   - read data, held until the next read ACK or reset
//            ack_o     - single-cycle transfer-complete pulse
//            rty_o     - registered "request present, not yet acknowledged"
// Revision : 1.0 - initial release
// ============================================================================
module wb_line_memory #(
  parameter int ADR_WIDTH = 12,
  parameter int LATENCY   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [ADR_WIDTH-1:0] adr_i,
  input  logic [15:0]          sel_i,
  input  logic [127:0]         dat_m_i,
  output logic [127:0]         dat_s_o,
  output logic                 ack_o,
  output logic                 rty_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int         C_DEPTH    = 1 << ADR_WIDTH;
  localparam logic [7:0] C_CNT_LOAD = 8'(LATENCY - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [15:0]          sel_q, sel_d;
  logic [127:0]         dat_q, dat_d;
  logic                 ack_q, ack_d;
  logic                 rty_q, rty_d;
  logic [127:0]         dat_s_q;
  logic [127:0]         mem_q [C_DEPTH];
  logic                 w_req;

  assign w_req = cyc_i && stb_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          we_d    = we_i;
          adr_d   = adr_i;
          sel_d   = sel_i;
          dat_d   = dat_m_i;
          cnt_d   = C_CNT_LOAD;
          state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Abort takes priority over the counter expiring on the same edge.
        if (!w_req) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ack_d = (state_d == ST_RESP);
    // RTY reflects the request seen at this edge, masked while acknowledging.
    rty_d = w_req && (state_d != ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= 16'd0;
      dat_q   <= 128'd0;
      ack_q   <= 1'b0;
      rty_q   <= 1'b0;
      dat_s_q <= 128'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      rty_q   <= rty_d;
      // adr_d/we_d already select the live bus values when accepting from
      // IDLE straight into RESP, so one read port covers every latency.
      if (state_d == ST_RESP && !we_d) begin
        dat_s_q <= mem_q[adr_d];
      end
    end
  end

  // Write commits at the edge that ends RESP; a reset on that edge drops it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ST_RESP && we_q) begin
      for (int i = 0; i < 16; i++) begin
        if (sel_q[i]) begin
          mem_q[adr_q][8*i +: 8] <= dat_q[8*i +: 8];
        end
      end
    end
  end

  assign dat_s_o = dat_s_q;
  assign ack_o   = ack_q;
  assign rty_o   = rty_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_line_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_line_memory
// Purpose  : Scoreboard bench for wb_line_memory. Two instances are driven,
//            one with LATENCY=4 and one with LATENCY=1. Issued transfers push
//            their expected ACK edge and read data; a negedge monitor pops
//            and compares on every ACK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_line_memory;

  localparam int AW = 12;

  typedef struct {
    bit           we;
    logic [AW-1:0] adr;
    logic [127:0] data;
    int           ack_edge;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst   [2];
  logic         cyc   [2];
  logic         stb   [2];
  logic         we    [2];
  logic [AW-1:0] adr  [2];
  logic [15:0]  sel   [2];
  logic [127:0] dat_m [2];
  logic [127:0] dat_s [2];
  logic         ack   [2];
  logic         rty   [2];

  exp_t         exp_q0 [$];
  exp_t         exp_q1 [$];
  logic [127:0] model [int];
  logic [127:0] last_rd [2];
  logic         prev_ack [2];
  logic         prev_rst [2];
  int           edge_n = 0;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  wb_line_memory #(.ADR_WIDTH(AW), .LATENCY(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .sel_i(sel[0]), .dat_m_i(dat_m[0]), .dat_s_o(dat_s[0]),
    .ack_o(ack[0]), .rty_o(rty[0])
  );

  wb_line_memory #(.ADR_WIDTH(AW), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .sel_i(sel[1]), .dat_m_i(dat_m[1]), .dat_s_o(dat_s[1]),
    .ack_o(ack[1]), .rty_o(rty[1])
  );

  function automatic int lat(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [127:0] model_rd(int d, logic [AW-1:0] a);
    int k;
    k = d * 4096 + int'(a);
    return model.exists(k) ? model[k] : 128'd0;
  endfunction

  task automatic check(string name, int d, logic [127:0] got, logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, d, got, want);
    end
  endtask

  // Expected response for a transfer accepted at edge acc_edge.
  task automatic push_txn(int d, bit w, logic [AW-1:0] a, logic [15:0] s,
                          logic [127:0] dm, int acc_edge, bit commit);
    exp_t e;
    logic [127:0] line;
    int k;
    e.we = w;
    e.adr = a;
    e.ack_edge = acc_edge + lat(d) - 1;
    e.data = 128'd0;
    if (w) begin
      if (commit) begin
        line = model_rd(d, a);
        for (int i = 0; i < 16; i++)
          if (s[i]) line[8*i +: 8] = dm[8*i +: 8];
        k = d * 4096 + int'(a);
        model[k] = line;
      end
    end else begin
      e.data = model_rd(d, a);
    end
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic drive(int d, bit w, logic [AW-1:0] a, logic [15:0] s, logic [127:0] dm);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_m[d] = dm;
  endtask

  // Returns positioned at the ACK negedge. While waiting RTY must be high;
  // optionally scrambles the bus to show latched values are used.
  task automatic wait_ack(int d, bit scramble, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack[d]) begin
        ok = 1'b1;
        break;
      end
      check("rty_wait", d, 128'(rty[d]), 128'd1);
      if (scramble) begin
        adr[d] = AW'($urandom); we[d] = 1'($urandom); sel[d] = 16'($urandom);
        dat_m[d] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (ok) check("rty_resp", d, 128'(rty[d]), 128'd0);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout dut%0d: got no ACK, expected ACK", d);
    end
  endtask

  task automatic txn(int d, bit w, logic [AW-1:0] a, logic [15:0] s,
                     logic [127:0] dm, int pre);
    bit ok;
    repeat (pre) @(negedge clk);
    drive(d, w, a, s, dm);
    push_txn(d, w, a, s, dm, edge_n + 1, 1'b1);
    wait_ack(d, 1'b1, ok);
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  // Write is acknowledged but reset hits the edge ending RESP.
  task automatic reset_in_resp(int d, logic [AW-1:0] a);
    bit ok;
    txn(d, 1'b1, a, 16'hFFFF, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2);
    repeat (2) @(negedge clk);
    drive(d, 1'b1, a, 16'hFFFF, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
    push_txn(d, 1'b1, a, 16'hFFFF, 128'd0, edge_n + 1, 1'b0);
    wait_ack(d, 1'b0, ok);
    rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0;
    @(negedge clk);
    check("rst_ack", d, 128'(ack[d]), 128'd0);
    check("rst_rty", d, 128'(rty[d]), 128'd0);
    check("rst_dat_s", d, dat_s[d], 128'd0);
    last_rd[d] = 128'd0;
    rst[d] = 1'b0;
    txn(d, 1'b0, a, 16'h0, 128'd0, 1);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d]) begin
        check("ack_pulse", d, 128'(prev_ack[d]), 128'd0);
        if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_ack dut%0d: got ACK at edge %0d, expected none", d, edge_n);
        end else begin
          exp_t e;
          if (d == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          check("ack_edge", d, 128'(edge_n), 128'(e.ack_edge));
          if (!e.we) begin
            check("rd_data", d, dat_s[d], e.data);
            last_rd[d] = e.data;
          end
        end
      end else if (!rst[d] && !prev_rst[d]) begin
        check("dat_s_hold", d, dat_s[d], last_rd[d]);
      end
      prev_ack[d] = ack[d];
      prev_rst[d] = rst[d];
    end
  end

  initial begin
    bit ok;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; sel[d] = 16'd0; dat_m[d] = 128'd0;
      last_rd[d] = 128'd0; prev_ack[d] = 1'b0; prev_rst[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ack", d, 128'(ack[d]), 128'd0);
      check("reset_rty", d, 128'(rty[d]), 128'd0);
      check("reset_dat_s", d, dat_s[d], 128'd0);
      rst[d] = 1'b0;
    end

    // ---------------- LATENCY = 4 ----------------
    txn(0, 1'b0, 12'h000, 16'h0, 128'd0, 1);
    txn(0, 1'b1, 12'h0A5, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2);
    txn(0, 1'b0, 12'h0A5, 16'h0, 128'd0, 2);
    txn(0, 1'b1, 12'h0A5, 16'h000F, {16{8'hAA}}, 2);
    txn(0, 1'b0, 12'h0A5, 16'h0, 128'd0, 2);

    // Abort: strobe dropped two cycles after acceptance, then a fresh read.
    repeat (2) @(negedge clk);
    drive(0, 1'b0, 12'h055, 16'h0, 128'd0);
    repeat (2) begin
      @(negedge clk);
      check("rty_abort", 0, 128'(rty[0]), 128'd1);
    end
    stb[0] = 1'b0;
    txn(0, 1'b0, 12'h001, 16'h0, 128'd0, 1);

    // Strobe held across ACK with a new address: one GAP then re-accept.
    repeat (2) @(negedge clk);
    drive(0, 1'b0, 12'h0A5, 16'h0, 128'd0);
    push_txn(0, 1'b0, 12'h0A5, 16'h0, 128'd0, edge_n + 1, 1'b1);
    wait_ack(0, 1'b1, ok);
    we[0] = 1'b0; adr[0] = 12'h001;
    push_txn(0, 1'b0, 12'h001, 16'h0, 128'd0, edge_n + 3, 1'b1);
    wait_ack(0, 1'b0, ok);
    cyc[0] = 1'b0; stb[0] = 1'b0;

    reset_in_resp(0, 12'h010);

    // ---------------- LATENCY = 1 ----------------
    txn(1, 1'b0, 12'h000, 16'h0, 128'd0, 1);
    txn(1, 1'b1, 12'h0A5, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2);
    txn(1, 1'b1, 12'h0A5, 16'h000F, {16{8'hAA}}, 2);
    txn(1, 1'b0, 12'h0A5, 16'h0, 128'd0, 2);
    reset_in_resp(1, 12'h010);

    // ---------------- randomized traffic on both ----------------
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        txn(d, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 16'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 2 + $urandom_range(0, 3));
      end
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 0, 128'(exp_q0.size() + exp_q1.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
